// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared constants and types for the ALU operand-capture datapath.
//   WIDTH      : operand width (only 8 is supported)
//   latch_st_e : operand latch state encoding (2'b11 is illegal)
package alu_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'b00,
      ST_HAVE_A = 2'b01,
      ST_FULL   = 2'b10
   } latch_st_e;

endpackage : alu_pkg

// File: rtl/register_8b.sv
// register_8b
//   Operand register with synchronous active-high reset and load enable.
//   clk_i : clock
//   rst_i : synchronous reset; clears q_o to zero
//   en_i  : load enable; captures d_i on the rising edge
//   d_i   : data in
//   q_o   : registered data out
module register_8b
   import alu_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)     data_q <= '0;
      else if (en_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule : register_8b

// File: rtl/operand_latch_8b.sv
// operand_latch_8b
//   Collects operand A then operand B (with add/subtract select) from the
//   shared data bus and holds them as a registered bundle for the
//   inverter/adder until downstream consumes it. Subtract is A + ~B + 1,
//   so the inverter enable and carry-in are both the latched sub flag,
//   gated to the FULL state.
//   input_clock     : clock
//   input_reset     : synchronous active-high reset
//   input_data      : data bus, sampled on input_load
//   input_load      : capture one operand this cycle
//   input_subtract  : op select, sampled with operand B (1 = subtract)
//   input_consume   : downstream takes the bundle (only acts in FULL)
//   output_a/_b     : captured operands
//   output_invert   : inverter enable
//   output_carry_in : adder carry-in (same as output_invert)
//   output_valid    : complete pair held
//   output_dropped  : sticky, a load arrived while FULL without consume
module operand_latch_8b
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             input_clock,
   input  logic             input_reset,
   input  logic [WIDTH-1:0] input_data,
   input  logic             input_load,
   input  logic             input_subtract,
   input  logic             input_consume,
   output logic [WIDTH-1:0] output_a,
   output logic [WIDTH-1:0] output_b,
   output logic             output_invert,
   output logic             output_carry_in,
   output logic             output_valid,
   output logic             output_dropped
);

   latch_st_e state_q, state_d;
   logic      sub_q, sub_d;
   logic      dropped_q, dropped_d;
   logic      valid_q, valid_d;
   logic      invert_q, invert_d;
   logic      load_a, load_b;

   // Next-state and capture enables
   always_comb begin
      state_d   = state_q;
      sub_d     = sub_q;
      dropped_d = dropped_q;
      load_a    = 1'b0;
      load_b    = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (input_load) begin
               load_a  = 1'b1;
               state_d = ST_HAVE_A;
            end
         end
         ST_HAVE_A: begin
            if (input_load) begin
               load_b  = 1'b1;
               sub_d   = input_subtract;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (input_consume) begin
               // Consume and a new A in the same cycle: no bubble.
               if (input_load) begin
                  load_a  = 1'b1;
                  state_d = ST_HAVE_A;
               end else begin
                  state_d = ST_EMPTY;
               end
            end else if (input_load) begin
               dropped_d = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // valid/invert are computed from the next state so that they leave the
   // block straight from flops rather than through a state decode.
   assign valid_d  = (state_d == ST_FULL);
   assign invert_d = (state_d == ST_FULL) && sub_d;

   always_ff @(posedge input_clock) begin
      if (input_reset) begin
         state_q   <= ST_EMPTY;
         sub_q     <= 1'b0;
         dropped_q <= 1'b0;
         valid_q   <= 1'b0;
         invert_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sub_q     <= sub_d;
         dropped_q <= dropped_d;
         valid_q   <= valid_d;
         invert_q  <= invert_d;
      end
   end

   register_8b #(.W(WIDTH)) u_reg_a (
      .clk_i (input_clock),
      .rst_i (input_reset),
      .en_i  (load_a),
      .d_i   (input_data),
      .q_o   (output_a)
   );

   register_8b #(.W(WIDTH)) u_reg_b (
      .clk_i (input_clock),
      .rst_i (input_reset),
      .en_i  (load_b),
      .d_i   (input_data),
      .q_o   (output_b)
   );

   assign output_invert   = invert_q;
   assign output_carry_in = invert_q;
   assign output_valid    = valid_q;
   assign output_dropped  = dropped_q;

endmodule : operand_latch_8b

// File: tb/tb_operand_latch_8b.sv
module tb_operand_latch_8b;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data = 8'h00;
   logic       load = 1'b0;
   logic       sub = 1'b0;
   logic       consume = 1'b0;
   logic [7:0] a, b;
   logic       inv, cin, valid, dropped;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       inv;
      logic       cin;
      logic       valid;
      logic       dropped;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   operand_latch_8b dut (
      .input_clock     (clk),
      .input_reset     (rst),
      .input_data      (data),
      .input_load      (load),
      .input_subtract  (sub),
      .input_consume   (consume),
      .output_a        (a),
      .output_b        (b),
      .output_invert   (inv),
      .output_carry_in (cin),
      .output_valid    (valid),
      .output_dropped  (dropped)
   );

   function automatic exp_t mk(input logic [7:0] ea, input logic [7:0] eb,
                               input logic ei, input logic ev, input logic ed);
      exp_t e;
      e.a = ea; e.b = eb; e.inv = ei; e.cin = ei; e.valid = ev; e.dropped = ed;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of stimulus, push the expected post-edge bundle,
   // then pop and compare it #1 after the edge.
   task automatic cyc(input string tag, input logic r, input logic l,
                      input logic [7:0] d, input logic s, input logic c,
                      input exp_t e);
      exp_t x;
      rst = r; load = l; data = d; sub = s; consume = c;
      sb.push_back(e);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({tag, ".a"},       a,              x.a);
      chk({tag, ".b"},       b,              x.b);
      chk({tag, ".inv"},     {7'd0, inv},     {7'd0, x.inv});
      chk({tag, ".cin"},     {7'd0, cin},     {7'd0, x.cin});
      chk({tag, ".valid"},   {7'd0, valid},   {7'd0, x.valid});
      chk({tag, ".dropped"}, {7'd0, dropped}, {7'd0, x.dropped});
      rst = 1'b0; load = 1'b0; consume = 1'b0; sub = 1'b0; data = 8'h00;
   endtask

   initial begin
      @(posedge clk); #1;
      //  tag           rst   load  data   sub   cons  expected a,b,inv,valid,dropped
      cyc("reset",     1'b1, 1'b0, 8'h00, 1'b0, 1'b0, mk(8'h00, 8'h00, 0, 0, 0));
      cyc("ldA_3c",    1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, mk(8'h3C, 8'h00, 0, 0, 0));
      cyc("ldB_05",    1'b0, 1'b1, 8'h05, 1'b0, 1'b0, mk(8'h3C, 8'h05, 0, 1, 0));
      cyc("cons1",     1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mk(8'h3C, 8'h05, 0, 0, 0));
      cyc("ldA_10",    1'b0, 1'b1, 8'h10, 1'b0, 1'b0, mk(8'h10, 8'h05, 0, 0, 0));
      cyc("ldB_01s",   1'b0, 1'b1, 8'h01, 1'b1, 1'b0, mk(8'h10, 8'h01, 1, 1, 0));
      cyc("cons_sub",  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mk(8'h10, 8'h01, 0, 0, 0));
      cyc("cons_empt", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mk(8'h10, 8'h01, 0, 0, 0));
      cyc("ldA_aa",    1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, mk(8'hAA, 8'h01, 0, 0, 0));
      cyc("cons_hva",  1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mk(8'hAA, 8'h01, 0, 0, 0));
      cyc("ldB_55",    1'b0, 1'b1, 8'h55, 1'b0, 1'b0, mk(8'hAA, 8'h55, 0, 1, 0));
      cyc("drop_ff",   1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, mk(8'hAA, 8'h55, 0, 1, 1));
      cyc("cons_ld77", 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, mk(8'h77, 8'h55, 0, 0, 1));
      cyc("ldB_01b",   1'b0, 1'b1, 8'h01, 1'b1, 1'b0, mk(8'h77, 8'h01, 1, 1, 1));
      cyc("cons2",     1'b0, 1'b0, 8'h00, 1'b0, 1'b1, mk(8'h77, 8'h01, 0, 0, 1));
      cyc("ldA_12",    1'b0, 1'b1, 8'h12, 1'b0, 1'b0, mk(8'h12, 8'h01, 0, 0, 1));
      cyc("rst_mid",   1'b1, 1'b1, 8'h34, 1'b1, 1'b1, mk(8'h00, 8'h00, 0, 0, 0));
      cyc("ldA_9a",    1'b0, 1'b1, 8'h9A, 1'b1, 1'b0, mk(8'h9A, 8'h00, 0, 0, 0));
      cyc("ldB_bc",    1'b0, 1'b1, 8'hBC, 1'b1, 1'b0, mk(8'h9A, 8'hBC, 1, 1, 0));
      cyc("thru_a21",  1'b0, 1'b1, 8'h21, 1'b0, 1'b1, mk(8'h21, 8'hBC, 0, 0, 0));
      cyc("thru_b43",  1'b0, 1'b1, 8'h43, 1'b0, 1'b0, mk(8'h21, 8'h43, 0, 1, 0));
      cyc("thru_a65",  1'b0, 1'b1, 8'h65, 1'b0, 1'b1, mk(8'h65, 8'h43, 0, 0, 0));
      cyc("thru_b87",  1'b0, 1'b1, 8'h87, 1'b1, 1'b0, mk(8'h65, 8'h87, 1, 1, 0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_operand_latch_8b

// File: doc/operand_latch_8b.md
# operand_latch_8b

Sequential operand-capture stage feeding the 8-bit bitwise inverter and adder in the ALU datapath. It collects two operands from the shared 8-bit data bus on successive load strobes and captures an add/subtract selector with the second operand. It then presents A, B, the inverter enable and the adder carry-in as a stable, registered bundle until downstream consumes it. Subtraction is realised downstream as A + ~B + 1, so this block drives the inverter's enable and the carry-in directly.

## Interface

Parameters:
- WIDTH, 8, operand width in bits. Only 8 is supported.

Ports:
- input_clock  in  1  single clock; all state changes on the rising edge
- input_reset  in  1  synchronous, active-high reset
- input_data  in  WIDTH  data bus value; sampled only on a load strobe
- input_load  in  1  load strobe; one operand is captured per cycle the strobe is high
- input_subtract  in  1  operation select, sampled together with operand B; 1 = subtract, 0 = add
- input_consume  in  1  downstream accepts the current bundle; meaningful only while output_valid = 1
- output_a  out  WIDTH  captured operand A
- output_b  out  WIDTH  captured operand B; drives the inverter data input
- output_invert  out  1  drives the inverter enable
- output_carry_in  out  1  adder carry-in; always equal to output_invert
- output_valid  out  1  high while a complete operand pair is held
- output_dropped  out  1  sticky flag: a load was discarded because the block was full

## Operation

- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
- State machine, registered state:
  - EMPTY
  - HAVE_A
  - FULL
- EMPTY:
  - input_load captures input_data into A.
  - Next state is HAVE_A.
- HAVE_A:
  - input_load captures input_data into B and input_subtract into the sub flag.
  - Next state is FULL.
- FULL:
  - output_valid = 1.
  - A, B and the sub flag are held stable.
  - input_consume with no input_load: next state is EMPTY.
  - input_consume with input_load in the same cycle: the consume takes effect, input_data is captured as the new A, and next state is HAVE_A. No bubble.
  - input_load with no input_consume: the load is discarded, output_dropped is set to 1, and the state stays FULL.
- input_consume outside FULL is ignored.
- output_invert = sub flag AND (state == FULL). It is forced to 0 in EMPTY and HAVE_A so the inverter passes B unchanged.
- output_carry_in = output_invert.
- output_a and output_b keep their last captured values in EMPTY and HAVE_A. They are not cleared on consume.
- output_dropped stays set until reset. No other event clears it.
- Reset overrides every other input, including reset in the middle of a pair. A half-loaded pair in HAVE_A is abandoned.

## Timing

- Every output is registered. There is no combinational path from any input to any output.
- Reset values, one cycle after input_reset is sampled high:
  - state = EMPTY
  - output_a = 8'h00
  - output_b = 8'h00
  - output_invert = 0
  - output_carry_in = 0
  - output_valid = 0
  - output_dropped = 0
- Load latency: a strobe sampled at edge n updates the captured register and the state, visible after edge n.
- Pair latency: the second load at edge n raises output_valid after edge n. The minimum gap from the first load to valid is 2 edges.
- Consume: a consume sampled at edge n lowers output_valid and output_invert after edge n.
- Throughput: one completed pair every 2 cycles with continuous load and consume.

## Structure

- Shared package `alu_pkg` holds:
  - WIDTH constant (8)
  - 2-bit state encoding: EMPTY = 2'b00, HAVE_A = 2'b01, FULL = 2'b10
  - State 2'b11 is illegal and returns to EMPTY on the next edge.
- One sub-module is natural: `register_8b`, an 8-bit register with synchronous reset and load enable.
  - Instantiate it twice, once for A and once for B.
  - Keep the sub flag, the dropped flag and the state in the top module.

## Test plan

- Reset, then load 8'h3C and load 8'h05 with input_subtract = 0:
  - after the second edge, output_a = 8'h3C, output_b = 8'h05, output_valid = 1, output_invert = 0, output_carry_in = 0.
- Load 8'h10, then load 8'h01 with input_subtract = 1:
  - output_invert = 1 and output_carry_in = 1.
  - After input_consume: output_valid = 0, output_invert = 0, and output_b still reads 8'h01.
- In FULL holding A = 8'hAA, B = 8'h55, apply input_load with 8'hFF and no consume:
  - A and B remain 8'hAA / 8'h55, output_dropped = 1, output_valid stays 1.
- In FULL, apply input_consume and input_load with 8'h77 in the same cycle:
  - next cycle output_valid = 0, output_a = 8'h77, state HAVE_A.
  - The following load of 8'h01 gives valid = 1.
- Load A = 8'h12, then assert input_reset before B:
  - all outputs return to their reset values, including output_dropped.
  - The next two loads form a fresh pair.
- Apply input_consume while EMPTY and while HAVE_A:
  - no state change, no output change.
